// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall encodings, eret code and enable levels for pipe_ctrl
package pipe_ctrl_pkg;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;
   localparam logic [5:0] STALL_ALL  = 6'b111111;

   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   localparam logic RST_ENABLE   = 1'b1;
   localparam logic FLUSH_ENABLE = 1'b1;

   // The deepest requesting stage wins, since it also holds every earlier stage.
   function automatic logic [5:0] stall_from_req(input logic id, input logic ex, input logic mem);
      if (mem)     return STALL_MEM;
      else if (ex) return STALL_EX;
      else if (id) return STALL_ID;
      else         return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// rtl/pipe_ctrl_sat_counter.sv - saturating up-counter with enable and synchronous clear
module pipe_ctrl_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en && (count_q != {W{1'b1}}))
         count_d = count_q + W'(1);
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge plus freeze/flush/refill redirect sequencer
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
   parameter int          REFILL_CYCLES = 2,
   parameter int          CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic [31:0]      excepttype_i,
   input  logic [31:0]      cp0_epc_i,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {IDLE, FREEZE, FLUSH, REFILL} state_t;

   localparam logic [3:0] REFILL_LOAD = 4'(REFILL_CYCLES - 1);

   state_t      state_q, state_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [3:0]  refill_q, refill_d;
   logic [5:0]  req_stall;

   always_comb begin
      req_stall = stall_from_req(stallreq_id, stallreq_ex, stallreq_mem);
      state_d   = state_q;
      flush_d   = 1'b0;
      new_pc_d  = new_pc_q;
      refill_d  = refill_q;
      stall     = STALL_NONE;
      case (state_q)
         IDLE: begin
            if (excepttype_i != 32'd0) begin
               stall    = STALL_ALL;
               state_d  = FREEZE;
               flush_d  = FLUSH_ENABLE;
               new_pc_d = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end else begin
               stall = req_stall;
            end
         end
         FREEZE: state_d = FLUSH;
         FLUSH: begin
            refill_d = REFILL_LOAD;
            state_d  = REFILL;
         end
         REFILL: begin
            // Exceptions here come from instructions already being flushed.
            stall = req_stall;
            if (!req_stall[0]) begin
               if (refill_q == 4'd0) state_d  = IDLE;
               else                  refill_d = refill_q - 4'd1;
            end
         end
      endcase
      if (rst == RST_ENABLE) stall = STALL_NONE;
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q  <= IDLE;
         flush_q  <= 1'b0;
         new_pc_q <= 32'd0;
         refill_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
         refill_q <= refill_d;
      end
   end

   // A reset landing on the flush-pulse cycle must not redirect the PC.
   assign flush  = flush_q & (rst != RST_ENABLE);
   assign new_pc = new_pc_q;
   assign busy   = (state_q != IDLE);

   pipe_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .en    (stall[0]),
      .count (stall_cycles)
   );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. Drives the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Merges stall requests from ID, EX and the MEM bus interface into the 6-bit stall vector.
- Sequences exception and eret redirection as a freeze → flush → refill sequence, emitting flush and new_pc toward the PC register.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
EXC_VECTOR, 32'h0000_0020, handler entry address loaded on any non-eret exception
REFILL_CYCLES, 2, cycles after flush during which new exceptions are masked (1..15)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
stallreq_id  in  1  ID stage requests stall (load-use)
stallreq_ex  in  1  EX stage requests stall (multi-cycle div/madd)
stallreq_mem  in  1  data bus not ready
excepttype_i  in  32  exception type from MEM stage; 0 = none
cp0_epc_i  in  32  current EPC from CP0
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush  out  1  flush all pipeline latches and load new_pc into PC
new_pc  out  32  redirect address, valid while flush=1
busy  out  1  FSM not IDLE
stall_cycles  out  CNT_W  count of cycles with stall[0]=1, saturating

Behaviour:
Reset and clocking:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset state: FSM IDLE, flush=0, new_pc=0, refill counter=0, stall_cycles=0, busy=0. Combinational stall output is 6'b000000 while rst=1.
- rst asserted in any state returns the FSM to IDLE on the next edge. Any pending flush is dropped.

FSM states: IDLE, FREEZE, FLUSH, REFILL.

IDLE:
- stall is driven combinationally by priority: stallreq_mem → 6'b011111; else stallreq_ex → 6'b001111; else stallreq_id → 6'b000111; else 6'b000000.
- When excepttype_i != 0, the cycle is a freeze cycle:
  - stall=6'b111111 combinationally, overriding all stall requests.
  - next state is FREEZE.
  - new_pc is registered: cp0_epc_i if excepttype_i == 32'h0000_000e (eret), else EXC_VECTOR.

FREEZE (1 cycle): registered flush=1, new_pc held, stall=6'b000000. Next state is FLUSH. This state is the flush-pulse cycle. The PC register gives flush priority over stall and loads new_pc on this edge.

FLUSH (1 cycle):
- flush=0, stall=6'b000000.
- Load the refill counter with REFILL_CYCLES-1. Next state is REFILL.

REFILL:
- excepttype_i is ignored, because stale MEM-stage content is being flushed.
- Stall requests are honoured with the IDLE priority.
- The counter decrements only when stall[0]=0. Go to IDLE when the counter reaches 0 with stall[0]=0.

Timing and flags:
- Latency: exception seen at cycle N → flush=1 during cycle N+1 → PC equals new_pc after the edge ending cycle N+1.
- flush is exactly one cycle wide per exception. It is never asserted together with a nonzero stall.
- busy=1 in FREEZE, FLUSH and REFILL.

Stall counter:
- stall_cycles increments on each edge where stall[0]=1, the freeze cycle included.
- It saturates at all-ones and does not wrap.

Simultaneous events:
- An exception together with any stallreq in IDLE: the exception wins (freeze vector).
- An exception arriving in FREEZE, FLUSH or REFILL is ignored and not queued.

Decomposition:
- Shared define file: stall vector encodings (STALL_NONE, STALL_ID, STALL_EX, STALL_MEM, STALL_ALL), the excepttype code for eret (32'h0000_000e), and the existing Flush/Branch/Rst_Enable macros.
- FSM state encodings stay local to the module.
- One natural sub-module: sat_counter (parameterised width, enable, synchronous clear), used for stall_cycles.

Test Plan:
- Reset: rst=1 for 3 cycles with random stallreqs and excepttype_i → stall=0, flush=0, new_pc=0, stall_cycles=0, busy=0.
- Stall priority: stallreq_id=1 → 6'b000111. Add stallreq_ex=1 → 6'b001111. Add stallreq_mem=1 → 6'b011111. Hold 5 cycles → stall_cycles=5.
- Syscall: excepttype_i=32'h8 at cycle N with stallreq_ex=1 → stall=6'b111111 at N; flush=1, new_pc=32'h20 at N+1; flush=0 at N+2; busy low after REFILL_CYCLES further unstalled cycles.
- Eret: cp0_epc_i=32'h0000_1234, excepttype_i=32'he → flush pulse with new_pc=32'h0000_1234.
- Masking and mid-reset: second exception during REFILL → no second flush. Repeat the syscall case with rst=1 during FREEZE → flush stays 0 and the FSM is IDLE next cycle.
- Saturation: CNT_W=4, stall[0] held 20 cycles → stall_cycles=4'hF, no wrap.
